// File: rtl/la_wave_reader_pkg.sv
// Shared constants, sample word type and display FSM states for the
// logic-analyzer wave reader.
package la_pkg;

  localparam int SAMPLES = 42;
  localparam int ADDR_W  = 6;
  localparam int CH      = 8;
  localparam int X0      = 10;
  localparam int Y0      = 0;
  localparam int CELL_W  = 15;
  localparam int LANE_H  = 60;
  localparam int ROW_HI  = 10;
  localparam int ROW_LO  = 50;

  localparam int LANE_W = $clog2(CH);
  localparam int ROW_W  = $clog2(LANE_H);
  localparam int COL_W  = $clog2(CELL_W);

  typedef logic [CH-1:0] sample_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } la_state_t;

endpackage

// File: rtl/la_wave_reader_raster_pos.sv
// Raster position tracker: turns hcnt/vcnt into trace-area coordinates
// (sample index, lane, row-in-lane, first column of a cell) using counters.
module la_raster_pos
  import la_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcnt,
  input  logic [10:0]       vcnt,
  output logic              in_area,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] addr,
  output logic [LANE_W-1:0] lane,
  output logic [ROW_W-1:0]  row,
  output logic              first
);

  localparam logic [10:0] H_LEN = 11'(SAMPLES * CELL_W);
  localparam logic [10:0] V_LEN = 11'(CH * LANE_H);

  logic [10:0]       h_rel;
  logic [10:0]       v_rel;
  logic              in_area_d;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_d;
  logic [ADDR_W-1:0] idx_d;
  logic [LANE_W-1:0] lane_d;
  logic [ROW_W-1:0]  row_d;

  // Offsets wrap to large values left of/above the origin, so one compare per axis.
  assign h_rel     = hcnt - 11'(X0);
  assign v_rel     = vcnt - 11'(Y0);
  assign in_area_d = (h_rel < H_LEN) && (v_rel < V_LEN);

  always_comb begin
    col_d  = col;
    idx_d  = idx;
    row_d  = row;
    lane_d = lane;
    if (hcnt == 11'(X0)) begin
      col_d = '0;
      idx_d = '0;
      if (vcnt == 11'(Y0)) begin
        row_d  = '0;
        lane_d = '0;
      end else if (row == ROW_W'(LANE_H - 1)) begin
        row_d = '0;
        if (lane != LANE_W'(CH - 1)) lane_d = lane + 1'b1;
      end else begin
        row_d = row + 1'b1;
      end
    end else if (col == COL_W'(CELL_W - 1)) begin
      col_d = '0;
      // Saturate so the reader never walks into unwritten RAM words.
      if (idx != ADDR_W'(SAMPLES - 1)) idx_d = idx + 1'b1;
    end else begin
      col_d = col + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_area <= 1'b0;
      col     <= '0;
      idx     <= '0;
      addr    <= '0;
      lane    <= '0;
      row     <= '0;
      first   <= 1'b0;
    end else begin
      in_area <= in_area_d;
      col     <= col_d;
      idx     <= idx_d;
      lane    <= lane_d;
      row     <= row_d;
      first   <= (col_d == '0);
      if (in_area_d) addr <= idx_d;
    end
  end

endmodule

// File: rtl/la_wave_reader.sv
// Logic-analyzer wave reader: addresses the capture RAM from the raster and
// renders 8 stacked traces with 3-cycle latency. LA_WAVE_GRID_EN adds a grid.
module la_wave_reader
  import la_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcnt,
  input  logic [10:0]       vcnt,
  input  logic              de,
  input  logic              frame_start,
  input  logic              cap_done,
  input  logic [CH-1:0]     ram_q,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_on,
  output logic              pix_grid,
  output logic              de_out,
  output logic              show
);

  la_state_t state_q;
  la_state_t state_d;

  logic              s1_in_area;
  logic              s1_first;
  logic [ADDR_W-1:0] s1_idx;
  logic [LANE_W-1:0] s1_lane;
  logic [ROW_W-1:0]  s1_row;
  logic              s1_de;

  logic              s2_in_area;
  logic              s2_first;
  logic              s2_idx0;
  logic [LANE_W-1:0] s2_lane;
  logic [ROW_W-1:0]  s2_row;
  logic              s2_de;
  sample_t           prev_word;

  logic [LANE_W-1:0] bit_sel;
  logic              b;
  logic              pb;
  logic              on_d;

  la_raster_pos u_pos (
    .clk     (clk),
    .rst     (rst),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .in_area (s1_in_area),
    .idx     (s1_idx),
    .addr    (rd_addr),
    .lane    (s1_lane),
    .row     (s1_row),
    .first   (s1_first)
  );

  // Display state only moves on frame_start so a frame is never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BLANK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      case (state_q)
        BLANK:   if (cap_done)  state_d = SHOW;
        SHOW:    if (!cap_done) state_d = BLANK;
        default: state_d = BLANK;
      endcase
    end
  end

  assign show = (state_q == SHOW);

  // prev_word holds the previous pixel's word; at a cell's first pixel that
  // is the previous sample. At sample 0 the current word stands in: no edge.
  always_comb begin
    bit_sel = LANE_W'(CH - 1) - s2_lane;
    b       = ram_q[bit_sel];
    pb      = s2_idx0 ? b : prev_word[bit_sel];
    on_d    = show && s2_in_area &&
              ((b && (s2_row == ROW_W'(ROW_HI))) ||
               (!b && (s2_row == ROW_W'(ROW_LO))) ||
               (s2_first && (b != pb) &&
                (s2_row >= ROW_W'(ROW_HI)) && (s2_row <= ROW_W'(ROW_LO))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_de      <= 1'b0;
      s2_de      <= 1'b0;
      de_out     <= 1'b0;
      s2_in_area <= 1'b0;
      s2_first   <= 1'b0;
      s2_idx0    <= 1'b0;
      s2_lane    <= '0;
      s2_row     <= '0;
      prev_word  <= '0;
      pix_on     <= 1'b0;
    end else begin
      s1_de      <= de;
      s2_de      <= s1_de;
      de_out     <= s2_de;
      s2_in_area <= s1_in_area;
      s2_first   <= s1_first;
      s2_idx0    <= (s1_idx == '0);
      s2_lane    <= s1_lane;
      s2_row     <= s1_row;
      prev_word  <= ram_q;
      pix_on     <= on_d;
    end
  end

`ifdef LA_WAVE_GRID_EN
  logic s1_h_even;
  logic s1_v_even;
  logic s2_grid;

  // Dotted grid: cell boundaries on even lines, lane tops on even columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_h_even <= 1'b0;
      s1_v_even <= 1'b0;
      s2_grid   <= 1'b0;
      pix_grid  <= 1'b0;
    end else begin
      s1_h_even <= ~hcnt[0];
      s1_v_even <= ~vcnt[0];
      s2_grid   <= s1_in_area &&
                   ((s1_first && s1_v_even) || ((s1_row == '0) && s1_h_even));
      pix_grid  <= s2_grid;
    end
  end
`else
  assign pix_grid = 1'b0;
`endif

endmodule

// File: tb/tb_la_wave_reader.sv
// Directed bench for la_wave_reader: drives short raster lines over a RAM
// model and checks trace, address, delay and show behaviour pixel by pixel.
`timescale 1ns/1ps
module tb_la_wave_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        de;
  logic        frame_start;
  logic        cap_done;
  logic [7:0]  ram_q;
  logic [5:0]  rd_addr;
  logic        pix_on;
  logic        pix_grid;
  logic        de_out;
  logic        show;

  logic [7:0]  mem [0:63];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   hh[3];
  int   hv[3];
  int   hd[3];
  int   hval[3];
  logic exp_show;
  logic pos_ok;

  la_wave_reader dut (
    .clk         (clk),
    .rst         (rst),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .de          (de),
    .frame_start (frame_start),
    .cap_done    (cap_done),
    .ram_q       (ram_q),
    .rd_addr     (rd_addr),
    .pix_on      (pix_on),
    .pix_grid    (pix_grid),
    .de_out      (de_out),
    .show        (show)
  );

  // clock / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (pix h=%0d v=%0d)", tag, obs, exp, hh[2], hv[2]);
    end
  endtask

  // Hand-derived trace for mem[0]=FF, mem[1..40]=00, mem[41]=80, lane 0.
  function automatic logic exp_pix(input int h, input int v);
    if (!exp_show || h < 10 || h > 639) return 1'b0;
    if (v == 10) return (h <= 25) || (h >= 625);
    if (v > 10 && v < 50) return (h == 25) || (h == 625);
    if (v == 50) return (h >= 25) && (h <= 625);
    return 1'b0;
  endfunction

  function automatic logic exp_grid(input int h, input int v);
`ifdef LA_WAVE_GRID_EN
    if (h < 10 || h > 639 || v > 479) return 1'b0;
    return ((((h - 10) % 15) == 0) && (v % 2 == 0)) || (((v % 60) == 0) && (h % 2 == 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input int h, input int v, input logic fs);
    hcnt        = 11'(h);
    vcnt        = 11'(v);
    de          = (h >= 2);
    frame_start = fs;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    for (int i = 2; i > 0; i--) begin
      hh[i] = hh[i-1]; hv[i] = hv[i-1]; hd[i] = hd[i-1]; hval[i] = hval[i-1];
    end
    hh[0] = h; hv[0] = v; hd[0] = (h >= 2) ? 1 : 0; hval[0] = 1;
    chk("show", 32'(show), 32'(exp_show));
    chk("rd_addr_max", 32'(rd_addr <= 6'd41), 32'd1);
    if (pos_ok && hh[0] >= 10 && hh[0] <= 639) chk("rd_addr", 32'(rd_addr), 32'((hh[0] - 10) / 15));
    if (pos_ok && hh[0] >= 640) chk("rd_addr_hold", 32'(rd_addr), 32'd41);
    if (hval[2] != 0) begin
      chk("de_out", 32'(de_out), 32'(hd[2]));
      chk("pix_on", 32'(pix_on), 32'(exp_pix(hh[2], hv[2])));
      if (pos_ok) chk("pix_grid", 32'(pix_grid), 32'(exp_grid(hh[2], hv[2])));
    end
  endtask

  task automatic line(input int v, input int width);
    for (int h = 0; h < width; h++) step(h, v, (v == 0 && h == 0));
  endtask

  initial begin
    rst = 1'b1; hcnt = '0; vcnt = '0; de = 1'b0; frame_start = 1'b0; cap_done = 1'b1;
    exp_show = 1'b0; pos_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin hh[i] = 0; hv[i] = 0; hd[i] = 0; hval[i] = 0; end
    mem[0] = 8'hFF;
    for (int a = 1; a < 41; a++) mem[a] = 8'h00;
    mem[41] = 8'h80;
    for (int a = 42; a < 64; a++) mem[a] = 8'hFF;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_pix_on", 32'(pix_on), 32'd0);
    chk("rst_pix_grid", 32'(pix_grid), 32'd0);
    chk("rst_de_out", 32'(de_out), 32'd0);
    chk("rst_show", 32'(show), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("show_wait_fs", 32'(show), 32'd0);

    // frame 1: data shown, long sweep line at v=10, cap_done dropped mid-frame
    exp_show = 1'b1; pos_ok = 1'b1;
    for (int v = 0; v < 62; v++) begin
      if (v == 20) cap_done = 1'b0;
      line(v, (v == 10) ? 661 : 30);
    end

    // frame 2: cap_done low at frame_start, nothing drawn
    exp_show = 1'b0;
    for (int v = 0; v < 62; v++) line(v, 30);

    // frame 3: shown again, reset asserted mid-line while drawing
    cap_done = 1'b1; exp_show = 1'b1;
    for (int v = 0; v < 10; v++) line(v, 30);
    for (int h = 0; h < 20; h++) step(h, 10, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
    chk("midrst_pix_on", 32'(pix_on), 32'd0);
    chk("midrst_de_out", 32'(de_out), 32'd0);
    chk("midrst_show", 32'(show), 32'd0);
    chk("midrst_pix_grid", 32'(pix_grid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_show = 1'b0; pos_ok = 1'b0;
    for (int i = 0; i < 3; i++) hval[i] = 0;
    for (int h = 20; h < 30; h++) step(h, 10, 1'b0);
    for (int v = 11; v < 62; v++) line(v, 30);

    // frame 4: drawing resumes after frame_start
    exp_show = 1'b1; pos_ok = 1'b1;
    for (int v = 0; v < 12; v++) line(v, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
